// File: rtl/dmem_responder.sv
// Fixed-latency data-memory slave with stall/done handshake (LAT cycles per access, LAT+1 peak period).
// Optional misaligned-access error reporting is enabled by defining DMEM_ERR_EN.
module dmem_responder #(
  parameter int LAT   = 2,
  parameter int WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        stall,
  output logic        done,
  output logic        err
);

  localparam int AW = $clog2(WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_nxt;
  logic [3:0]      count;
  logic            wr_q, mis_q;
  logic [AW-1:0]   idx_q;
  logic [15:0]     wdat_q;
  logic [15:0]     mem [WORDS];

  logic            acc, commit;
  logic            in_mis;
  logic            op_wr, op_mis;
  logic [AW-1:0]   op_idx;
  logic [15:0]     op_dat;

`ifdef DMEM_ERR_EN
  assign in_mis = addr[0];
  logic unused_addr;
  assign unused_addr = ^addr[15:AW+1];
`else
  assign in_mis = 1'b0;
  logic unused_addr;
  assign unused_addr = ^{addr[15:AW+1], addr[0]};
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    acc       = 1'b0;
    case (state)
      IDLE: if (enable) begin
        acc       = 1'b1;
        state_nxt = (LAT == 1) ? DONE : BUSY;
      end
      BUSY: if (count == 4'(LAT - 1)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With LAT=1 the array access happens on the accept edge, so take the live inputs.
  assign commit = (state_nxt == DONE) && (state != DONE);
  assign op_wr  = (state == IDLE) ? wr            : wr_q;
  assign op_mis = (state == IDLE) ? in_mis        : mis_q;
  assign op_idx = (state == IDLE) ? addr[AW:1]    : idx_q;
  assign op_dat = (state == IDLE) ? data_in       : wdat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      data_out <= '0;
      wr_q     <= 1'b0;
      mis_q    <= 1'b0;
      idx_q    <= '0;
      wdat_q   <= '0;
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
    end else begin
      if (acc) begin
        wr_q   <= wr;
        mis_q  <= in_mis;
        idx_q  <= addr[AW:1];
        wdat_q <= data_in;
        count  <= 4'd1;
      end else if (state == BUSY) begin
        count <= count + 4'd1;
      end
      if (commit && !op_mis) begin
        if (op_wr) mem[op_idx] <= op_dat;
        else       data_out    <= mem[op_idx];
      end
    end
  end

  assign stall = (state == BUSY);
  assign done  = (state == DONE);
  assign err   = (state == DONE) && mis_q;

endmodule
